mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single external memory port between the instruction-cache and data-cache miss paths of the pipelined RISC-V core. Allows one outstanding transaction at a time. Uses round-robin arbitration when both caches request in the same cycle. Returns read data as a burst of BEATS beats to the owning cache; a write is issued as a single beat and gets no response.

Parameters:
ADDR_W, 28, memory block-address width
DATA_W, 128, memory data-beat width
BEATS, 4, response beats per read (cache line = BEATS*DATA_W)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
ic_req_valid  in  1  icache read request
ic_req_ready  out  1  icache request accepted this cycle
ic_req_addr  in  ADDR_W  icache read address
ic_resp_valid  out  1  response beat for icache
dc_req_valid  in  1  dcache request
dc_req_ready  out  1  dcache request accepted this cycle
dc_req_rw  in  1  1=write, 0=read
dc_req_addr  in  ADDR_W  dcache address
dc_req_wdata  in  DATA_W  dcache write data
dc_resp_valid  out  1  response beat for dcache
resp_data  out  DATA_W  shared response data, valid with either *_resp_valid
resp_last  out  1  final beat of current read burst
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  1=write
mem_req_addr  out  ADDR_W  latched address
mem_req_data  out  DATA_W  latched write data
mem_resp_valid  in  1  memory read beat
mem_resp_data  in  DATA_W  memory read data

Behaviour:
- Reset (async, active-high): state=IDLE, beat_cnt=0, owner=IC, last_grant=IC.
- Reset values of outputs: all *_ready, *_valid, resp_last and mem_req_rw are 0; mem_req_addr, mem_req_data and resp_data are 0.
- Reset mid-transaction abandons the transaction. No response beat is emitted after reset is asserted.
- IDLE state:
  - Only state where *_req_ready can be 1.
  - Ready is combinational: winner's ready = its valid and no other output is high.
  - Winner selection: if only one requester is valid, it wins. If both are valid, the one not equal to last_grant wins. Because last_grant resets to IC, dcache wins the first tie.
  - On fire: latch addr, rw (IC forced to 0), wdata (IC: 0), owner; last_grant<=winner; go to ISSUE.
- ISSUE state:
  - mem_req_valid=1, driven from latched registers. Latched fields stay stable until mem_req_ready.
  - On mem_req_valid and mem_req_ready: write goes to IDLE; read goes to RESP with beat_cnt<=0.
- RESP state:
  - Each mem_resp_valid cycle: owner's *_resp_valid=1 in the same cycle (combinational pass-through); resp_data=mem_resp_data; resp_last=(beat_cnt==BEATS-1); beat_cnt++.
  - On the last beat, go to IDLE.
  - Responses cannot be back-pressured; caches must sink them.
- mem_resp_valid in IDLE or ISSUE is ignored: no *_resp_valid, no state change.
- Latency: request fires in cycle T, mem_req_valid is high in T+1. After a read's last beat in cycle L, the earliest next grant is L+1. After a write handshake in cycle W, the earliest next grant is W+1.
- Only one of ic_resp_valid and dc_resp_valid is ever high. resp_data is 0 when neither is high.
- beat_cnt width is clog2(BEATS), minimum 1. BEATS=1 makes every read beat the last beat.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds output ports ic_grant_cnt[31:0] and dc_grant_cnt[31:0], both reset to 0.
  - Each increments by 1 in the cycle after its requester's request fires; wraps at 2^32.
  - Adds output stray_resp_cnt[15:0], which increments on each ignored mem_resp_valid and saturates at 16'hFFFF.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

Test Plan:
1. IC-only read: ic_req_valid=1, ic_req_addr=28'h0000123; mem_req_ready=1 at T+1; memory returns beats 128'hA0..A3 on 4 cycles.
   - Required: ic_req_ready=1 at T; mem_req_valid=1, mem_req_rw=0, mem_req_addr=28'h0000123 at T+1.
   - Required: four ic_resp_valid beats with matching data; resp_last only on beat A3; dc_resp_valid stays 0.
2. DC write: dc_req_rw=1, addr 28'h0000040, wdata 128'hDEADBEEF; hold mem_req_ready=0 for 3 cycles, then 1.
   - Required: mem_req_valid, addr and data stay stable through the stall; return to IDLE; no resp_valid.
3. Tie arbitration: ic and dc valid together out of reset for three back-to-back reads.
   - Required: grant order DC, IC, DC.
   - Required: each response routes only to its owner.
4. Stray beat: pulse mem_resp_valid while in IDLE and while in ISSUE.
   - Required: no resp_valid and no state change.
   - Required with MEM_ARB_STATS_EN: stray_resp_cnt=2.
5. Reset mid-burst: assert reset after beat 2 of an IC read.
   - Required: all outputs 0 immediately; state IDLE.
   - Required: next tie after reset is granted to DC; no leftover resp beats.
6. BEATS=1 build: a single read beat asserts resp_last, and the next grant is accepted in the following cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/dcache request+response and memory port bundle for mem_arbiter
// slave: arbiter side (drives ready/resp/mem_req); master: cache+memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_wdata;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  modport slave (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, resp_data, resp_last,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
  modport master (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, resp_data, resp_last,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin icache/dcache arbiter for one outstanding memory transaction
// Ports: clk, reset (async active-high), bus (mem_arbiter_if.slave).
// MEM_ARB_STATS_EN adds ic_grant_cnt, dc_grant_cnt, stray_resp_cnt outputs.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]   ic_grant_cnt,
  output logic [31:0]   dc_grant_cnt,
  output logic [15:0]   stray_resp_cnt
`endif
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] beat_cnt;
  logic owner, last_grant, rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic dc_win, ic_fire, dc_fire, resp_fire, last_beat, issue_fire;
  // owner/last_grant encoding: 0 = icache, 1 = dcache
  always_comb begin
    dc_win = bus.dc_req_valid & (~bus.ic_req_valid | ~last_grant);
    ic_fire = state == IDLE & bus.ic_req_valid & ~dc_win;
    dc_fire = state == IDLE & dc_win;
    issue_fire = state == ISSUE & bus.mem_req_ready;
    resp_fire = state == RESP & bus.mem_resp_valid;
    last_beat = beat_cnt == CW'(BEATS - 1);
    bus.ic_req_ready = ic_fire;
    bus.dc_req_ready = dc_fire;
    bus.mem_req_valid = state == ISSUE;
    bus.mem_req_rw = rw_q;
    bus.mem_req_addr = addr_q;
    bus.mem_req_data = data_q;
    bus.ic_resp_valid = resp_fire & ~owner;
    bus.dc_resp_valid = resp_fire & owner;
    bus.resp_data = resp_fire ? bus.mem_resp_data : '0;
    bus.resp_last = resp_fire & last_beat;
    state_nx = state == IDLE  ? (ic_fire | dc_fire ? ISSUE : IDLE) :
               state == ISSUE ? (issue_fire ? (rw_q ? IDLE : RESP) : ISSUE) :
                                (resp_fire & last_beat ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      owner <= 1'b0;
      last_grant <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (ic_fire | dc_fire) begin
        owner <= dc_fire;
        last_grant <= dc_fire;
        rw_q <= dc_fire & bus.dc_req_rw;
        addr_q <= dc_fire ? bus.dc_req_addr : bus.ic_req_addr;
        data_q <= dc_fire ? bus.dc_req_wdata : '0;
      end
      if (issue_fire) beat_cnt <= '0;
      else if (resp_fire) beat_cnt <= beat_cnt + 1'b1;
    end
  end
`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ic_grant_cnt <= '0;
      dc_grant_cnt <= '0;
      stray_resp_cnt <= '0;
    end else begin
      if (ic_fire) ic_grant_cnt <= ic_grant_cnt + 1'b1;
      if (dc_fire) dc_grant_cnt <= dc_grant_cnt + 1'b1;
      if (bus.mem_resp_valid & state != RESP & stray_resp_cnt != 16'hFFFF) stray_resp_cnt <= stray_resp_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (BEATS=4 and BEATS=1 instances)
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cmp = 0;
  int err = 0;
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) a ();
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) b ();
`ifdef MEM_ARB_STATS_EN
  logic [31:0] a_ic_cnt, a_dc_cnt, b_ic_cnt, b_dc_cnt;
  logic [15:0] a_stray, b_stray;
`endif
  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .BEATS(4)) u0 (
    .clk(clk), .reset(reset), .bus(a.slave)
`ifdef MEM_ARB_STATS_EN
    , .ic_grant_cnt(a_ic_cnt), .dc_grant_cnt(a_dc_cnt), .stray_resp_cnt(a_stray)
`endif
  );
  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .BEATS(1)) u1 (
    .clk(clk), .reset(reset), .bus(b.slave)
`ifdef MEM_ARB_STATS_EN
    , .ic_grant_cnt(b_ic_cnt), .dc_grant_cnt(b_dc_cnt), .stray_resp_cnt(b_stray)
`endif
  );
  always #5 clk = ~clk;

  task automatic test_reset;
    #1;
    cmp++; if (a.ic_req_ready !== 1'b0 || a.dc_req_ready !== 1'b0) begin err++; $display("FAIL rst_ready got ic=%b dc=%b want 0 0", a.ic_req_ready, a.dc_req_ready); end
    cmp++; if (a.ic_resp_valid !== 1'b0 || a.dc_resp_valid !== 1'b0 || a.resp_last !== 1'b0) begin err++; $display("FAIL rst_resp got %b%b%b want 000", a.ic_resp_valid, a.dc_resp_valid, a.resp_last); end
    cmp++; if (a.mem_req_valid !== 1'b0 || a.mem_req_rw !== 1'b0) begin err++; $display("FAIL rst_mem got v=%b rw=%b want 0 0", a.mem_req_valid, a.mem_req_rw); end
    cmp++; if (a.mem_req_addr !== 28'h0 || a.mem_req_data !== 128'h0 || a.resp_data !== 128'h0) begin err++; $display("FAIL rst_data got %h %h %h want 0", a.mem_req_addr, a.mem_req_data, a.resp_data); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ic_read;
    a.ic_req_valid = 1'b1; a.ic_req_addr = 28'h0000123;
    #1;
    cmp++; if (a.ic_req_ready !== 1'b1 || a.dc_req_ready !== 1'b0) begin err++; $display("FAIL ic_ready got ic=%b dc=%b want 1 0", a.ic_req_ready, a.dc_req_ready); end
    cmp++; if (a.mem_req_valid !== 1'b0) begin err++; $display("FAIL ic_memv_T got %b want 0", a.mem_req_valid); end
    @(negedge clk);
    a.ic_req_valid = 1'b0; a.ic_req_addr = 28'h0; a.mem_req_ready = 1'b1;
    #1;
    cmp++; if (a.mem_req_valid !== 1'b1 || a.mem_req_rw !== 1'b0) begin err++; $display("FAIL ic_issue got v=%b rw=%b want 1 0", a.mem_req_valid, a.mem_req_rw); end
    cmp++; if (a.mem_req_addr !== 28'h0000123) begin err++; $display("FAIL ic_addr got %h want 0000123", a.mem_req_addr); end
    @(negedge clk);
    a.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a.mem_resp_valid = 1'b1; a.mem_resp_data = 128'hA0 + 128'(i);
      #1;
      cmp++; if (a.ic_resp_valid !== 1'b1 || a.dc_resp_valid !== 1'b0) begin err++; $display("FAIL ic_beat%0d_valid got ic=%b dc=%b want 1 0", i, a.ic_resp_valid, a.dc_resp_valid); end
      cmp++; if (a.resp_data !== 128'hA0 + 128'(i)) begin err++; $display("FAIL ic_beat%0d_data got %h want %h", i, a.resp_data, 128'hA0 + 128'(i)); end
      cmp++; if (a.resp_last !== (i == 3)) begin err++; $display("FAIL ic_beat%0d_last got %b want %b", i, a.resp_last, i == 3); end
      @(negedge clk);
    end
    a.mem_resp_valid = 1'b0;
    #1;
    cmp++; if (a.ic_resp_valid !== 1'b0 || a.mem_req_valid !== 1'b0) begin err++; $display("FAIL ic_done got resp=%b memv=%b want 0 0", a.ic_resp_valid, a.mem_req_valid); end
    @(negedge clk);
  endtask

  task automatic test_dc_write;
    a.dc_req_valid = 1'b1; a.dc_req_rw = 1'b1; a.dc_req_addr = 28'h0000040; a.dc_req_wdata = 128'hDEADBEEF;
    #1;
    cmp++; if (a.dc_req_ready !== 1'b1 || a.ic_req_ready !== 1'b0) begin err++; $display("FAIL dw_ready got dc=%b ic=%b want 1 0", a.dc_req_ready, a.ic_req_ready); end
    @(negedge clk);
    a.dc_req_valid = 1'b0; a.dc_req_rw = 1'b0; a.dc_req_addr = 28'h0; a.dc_req_wdata = 128'h0;
    for (int k = 0; k < 4; k++) begin
      a.mem_req_ready = (k == 3);
      #1;
      cmp++; if (a.mem_req_valid !== 1'b1 || a.mem_req_rw !== 1'b1) begin err++; $display("FAIL dw_stall%0d got v=%b rw=%b want 1 1", k, a.mem_req_valid, a.mem_req_rw); end
      cmp++; if (a.mem_req_addr !== 28'h0000040 || a.mem_req_data !== 128'hDEADBEEF) begin err++; $display("FAIL dw_hold%0d got %h %h want 0000040 deadbeef", k, a.mem_req_addr, a.mem_req_data); end
      @(negedge clk);
    end
    a.mem_req_ready = 1'b0; a.mem_resp_valid = 1'b1; a.mem_resp_data = 128'h77;
    #1;
    cmp++; if (a.mem_req_valid !== 1'b0 || a.ic_resp_valid !== 1'b0 || a.dc_resp_valid !== 1'b0) begin err++; $display("FAIL dw_idle got memv=%b ic=%b dc=%b want 0 0 0", a.mem_req_valid, a.ic_resp_valid, a.dc_resp_valid); end
    @(negedge clk);
    a.mem_resp_valid = 1'b0;
  endtask

  task automatic test_tie;
    logic want_dc;
    for (int g = 0; g < 3; g++) begin
      want_dc = (g != 1);
      a.ic_req_valid = 1'b1; a.dc_req_valid = 1'b1; a.dc_req_rw = 1'b0;
      a.ic_req_addr = 28'h100 + 28'(g); a.dc_req_addr = 28'h200 + 28'(g);
      #1;
      cmp++; if (a.dc_req_ready !== want_dc || a.ic_req_ready !== !want_dc) begin err++; $display("FAIL tie%0d_grant got dc=%b ic=%b want %b %b", g, a.dc_req_ready, a.ic_req_ready, want_dc, !want_dc); end
      @(negedge clk);
      a.ic_req_valid = 1'b0; a.dc_req_valid = 1'b0; a.mem_req_ready = 1'b1;
      #1;
      cmp++; if (a.mem_req_addr !== (want_dc ? 28'h200 : 28'h100) + 28'(g)) begin err++; $display("FAIL tie%0d_addr got %h want %h", g, a.mem_req_addr, (want_dc ? 28'h200 : 28'h100) + 28'(g)); end
      @(negedge clk);
      a.mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        a.mem_resp_valid = 1'b1; a.mem_resp_data = 128'h1000 + 128'(g * 16 + i);
        #1;
        cmp++; if (a.dc_resp_valid !== want_dc || a.ic_resp_valid !== !want_dc) begin err++; $display("FAIL tie%0d_beat%0d_route got dc=%b ic=%b want %b %b", g, i, a.dc_resp_valid, a.ic_resp_valid, want_dc, !want_dc); end
        @(negedge clk);
      end
      a.mem_resp_valid = 1'b0;
    end
  endtask

  task automatic test_stray;
    a.mem_resp_valid = 1'b1; a.mem_resp_data = 128'hFF;
    #1;
    cmp++; if (a.ic_resp_valid !== 1'b0 || a.dc_resp_valid !== 1'b0 || a.resp_data !== 128'h0) begin err++; $display("FAIL stray_idle got ic=%b dc=%b data=%h want 0 0 0", a.ic_resp_valid, a.dc_resp_valid, a.resp_data); end
    @(negedge clk);
    a.mem_resp_valid = 1'b0; a.ic_req_valid = 1'b1; a.ic_req_addr = 28'h55;
    #1;
    cmp++; if (a.ic_req_ready !== 1'b1) begin err++; $display("FAIL stray_still_idle got %b want 1", a.ic_req_ready); end
    @(negedge clk);
    a.ic_req_valid = 1'b0; a.mem_resp_valid = 1'b1;
    #1;
    cmp++; if (a.ic_resp_valid !== 1'b0 || a.resp_last !== 1'b0 || a.mem_req_valid !== 1'b1) begin err++; $display("FAIL stray_issue got resp=%b last=%b memv=%b want 0 0 1", a.ic_resp_valid, a.resp_last, a.mem_req_valid); end
    @(negedge clk);
    a.mem_resp_valid = 1'b0; a.mem_req_ready = 1'b1;
    #1;
    cmp++; if (a.mem_req_valid !== 1'b1 || a.mem_req_addr !== 28'h55) begin err++; $display("FAIL stray_still_issue got v=%b addr=%h want 1 55", a.mem_req_valid, a.mem_req_addr); end
    @(negedge clk);
    a.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a.mem_resp_valid = 1'b1; a.mem_resp_data = 128'hC0 + 128'(i);
      #1;
      cmp++; if (a.ic_resp_valid !== 1'b1 || a.resp_last !== (i == 3)) begin err++; $display("FAIL stray_beat%0d got v=%b last=%b want 1 %b", i, a.ic_resp_valid, a.resp_last, i == 3); end
      @(negedge clk);
    end
    a.mem_resp_valid = 1'b0;
`ifdef MEM_ARB_STATS_EN
    #1;
    cmp++; if (a_stray !== 16'd2) begin err++; $display("FAIL stats_stray got %0d want 2", a_stray); end
    cmp++; if (a_ic_cnt !== 32'd2 || a_dc_cnt !== 32'd2) begin err++; $display("FAIL stats_grants got ic=%0d dc=%0d want 2 2", a_ic_cnt, a_dc_cnt); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    a.ic_req_valid = 1'b1; a.ic_req_addr = 28'h77;
    @(negedge clk);
    a.ic_req_valid = 1'b0; a.mem_req_ready = 1'b1;
    @(negedge clk);
    a.mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a.mem_resp_valid = 1'b1; a.mem_resp_data = 128'hB0 + 128'(i);
      @(negedge clk);
    end
    a.mem_resp_data = 128'hB2; reset = 1'b1;
    #1;
    cmp++; if (a.ic_resp_valid !== 1'b0 || a.resp_data !== 128'h0 || a.resp_last !== 1'b0) begin err++; $display("FAIL rmid_resp got v=%b data=%h last=%b want 0 0 0", a.ic_resp_valid, a.resp_data, a.resp_last); end
    cmp++; if (a.mem_req_valid !== 1'b0 || a.mem_req_rw !== 1'b0 || a.mem_req_addr !== 28'h0) begin err++; $display("FAIL rmid_mem got v=%b rw=%b addr=%h want 0 0 0", a.mem_req_valid, a.mem_req_rw, a.mem_req_addr); end
    @(negedge clk);
    reset = 1'b0; a.mem_resp_data = 128'hB3;
    #1;
    cmp++; if (a.ic_resp_valid !== 1'b0 || a.dc_resp_valid !== 1'b0) begin err++; $display("FAIL rmid_leftover got ic=%b dc=%b want 0 0", a.ic_resp_valid, a.dc_resp_valid); end
    @(negedge clk);
    a.mem_resp_valid = 1'b0; a.ic_req_valid = 1'b1; a.dc_req_valid = 1'b1; a.dc_req_rw = 1'b0;
    #1;
    cmp++; if (a.dc_req_ready !== 1'b1 || a.ic_req_ready !== 1'b0) begin err++; $display("FAIL rmid_tie got dc=%b ic=%b want 1 0", a.dc_req_ready, a.ic_req_ready); end
`ifdef MEM_ARB_STATS_EN
    cmp++; if (a_stray !== 16'd1) begin err++; $display("FAIL rmid_stats_stray got %0d want 1", a_stray); end
`endif
    @(negedge clk);
    a.ic_req_valid = 1'b0; a.dc_req_valid = 1'b0;
  endtask

  task automatic test_beats1;
    b.ic_req_valid = 1'b1; b.ic_req_addr = 28'h9;
    #1;
    cmp++; if (b.ic_req_ready !== 1'b1) begin err++; $display("FAIL b1_ready got %b want 1", b.ic_req_ready); end
    @(negedge clk);
    b.ic_req_valid = 1'b0; b.mem_req_ready = 1'b1;
    @(negedge clk);
    b.mem_req_ready = 1'b0; b.mem_resp_valid = 1'b1; b.mem_resp_data = 128'hE0;
    #1;
    cmp++; if (b.ic_resp_valid !== 1'b1 || b.resp_last !== 1'b1 || b.resp_data !== 128'hE0) begin err++; $display("FAIL b1_beat got v=%b last=%b data=%h want 1 1 e0", b.ic_resp_valid, b.resp_last, b.resp_data); end
    @(negedge clk);
    b.mem_resp_valid = 1'b0; b.ic_req_valid = 1'b1;
    #1;
    cmp++; if (b.ic_req_ready !== 1'b1) begin err++; $display("FAIL b1_next_grant got %b want 1", b.ic_req_ready); end
    @(negedge clk);
    b.ic_req_valid = 1'b0;
  endtask

  initial begin
    {a.ic_req_valid, a.dc_req_valid, a.dc_req_rw, a.mem_req_ready, a.mem_resp_valid} = '0;
    {b.ic_req_valid, b.dc_req_valid, b.dc_req_rw, b.mem_req_ready, b.mem_resp_valid} = '0;
    a.ic_req_addr = '0; a.dc_req_addr = '0; a.dc_req_wdata = '0; a.mem_resp_data = '0;
    b.ic_req_addr = '0; b.dc_req_addr = '0; b.dc_req_wdata = '0; b.mem_resp_data = '0;
    @(negedge clk);
    test_reset;
    test_ic_read;
    test_dc_write;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_tie;
    test_stray;
    test_reset_mid;
    test_beats1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
